// File: rtl/instr_dec_pkg.sv
// Shared widths, field offsets, opcode constants and the decoded-record type
// for the block instruction decode pipeline.
package instr_dec_pkg;

    localparam int DATA_WIDTH     = 16;
    localparam int OP_WIDTH       = 5;
    localparam int REG_ADDR_WIDTH = 4;
    localparam int RES_ADDR_WIDTH = 8;
    localparam int PMS_WIDTH      = 4;
    localparam int SHIFT_WIDTH    = 5;
    localparam int HAZARD_DEPTH   = 4;
    localparam int INSTR_WIDTH    = OP_WIDTH + 4*REG_ADDR_WIDTH + 5 + PMS_WIDTH;

    // Format A: op | src_a | src_b | src_c | dest | type a,b,c,d | no-sat | pms
    localparam int A_SRC_A_LSB = OP_WIDTH;
    localparam int A_SRC_B_LSB = A_SRC_A_LSB + REG_ADDR_WIDTH;
    localparam int A_SRC_C_LSB = A_SRC_B_LSB + REG_ADDR_WIDTH;
    localparam int A_DEST_LSB  = A_SRC_C_LSB + REG_ADDR_WIDTH;
    localparam int A_TYPE_LSB  = A_DEST_LSB + REG_ADDR_WIDTH;
    localparam int A_NOSAT_BIT = A_TYPE_LSB + 4;
    localparam int A_PMS_LSB   = A_NOSAT_BIT + 1;

    // Format B: op | src_a | src_b | dest | res_addr
    localparam int B_SRC_A_LSB = OP_WIDTH;
    localparam int B_SRC_B_LSB = B_SRC_A_LSB + REG_ADDR_WIDTH;
    localparam int B_DEST_LSB  = B_SRC_B_LSB + REG_ADDR_WIDTH;
    localparam int B_RES_LSB   = B_DEST_LSB + REG_ADDR_WIDTH;

    localparam logic [OP_WIDTH-1:0] OP_NOP   = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_ADD   = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_SUB   = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_MUL   = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_MAC   = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_DELAY = OP_WIDTH'(16);
    localparam logic [OP_WIDTH-1:0] OP_SAVE  = OP_WIDTH'(17);
    localparam logic [OP_WIDTH-1:0] OP_LOAD  = OP_WIDTH'(18);
    localparam logic [OP_WIDTH-1:0] OP_MOV   = OP_WIDTH'(19);

    typedef enum logic {FMT_A, FMT_B} fmt_e;
    typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_e;

    typedef struct packed {
        logic [OP_WIDTH-1:0]       operation;
        logic [REG_ADDR_WIDTH-1:0] src_a;
        logic [REG_ADDR_WIDTH-1:0] src_b;
        logic [REG_ADDR_WIDTH-1:0] src_c;
        logic [REG_ADDR_WIDTH-1:0] dest;
        logic                      src_a_reg;
        logic                      src_b_reg;
        logic                      src_c_reg;
        logic                      dest_reg;
        logic                      saturate;
        logic [SHIFT_WIDTH-1:0]    instr_shift;
        logic [RES_ADDR_WIDTH-1:0] res_addr;
        fmt_e                      fmt;
    } instr_rec_t;

    function automatic logic is_format_b(input logic [OP_WIDTH-1:0] op);
        return (op == OP_DELAY) || (op == OP_SAVE) || (op == OP_LOAD) || (op == OP_MOV);
    endfunction

endpackage

// File: rtl/instr_field_extract.sv
// Combinational split of a raw block instruction into a decoded record.
module instr_field_extract
    import instr_dec_pkg::*;
(
    input  logic [INSTR_WIDTH-1:0] instr,
    output instr_rec_t             rec
);

    always_comb begin
        rec           = '0;
        rec.operation = instr[OP_WIDTH-1:0];
        if (is_format_b(instr[OP_WIDTH-1:0])) begin
            rec.fmt      = FMT_B;
            rec.src_a    = instr[B_SRC_A_LSB +: REG_ADDR_WIDTH];
            rec.src_b    = instr[B_SRC_B_LSB +: REG_ADDR_WIDTH];
            rec.dest     = instr[B_DEST_LSB +: REG_ADDR_WIDTH];
            rec.res_addr = instr[B_RES_LSB +: RES_ADDR_WIDTH];
        end else begin
            rec.fmt         = FMT_A;
            rec.src_a       = instr[A_SRC_A_LSB +: REG_ADDR_WIDTH];
            rec.src_b       = instr[A_SRC_B_LSB +: REG_ADDR_WIDTH];
            rec.src_c       = instr[A_SRC_C_LSB +: REG_ADDR_WIDTH];
            rec.dest        = instr[A_DEST_LSB +: REG_ADDR_WIDTH];
            rec.src_a_reg   = instr[A_TYPE_LSB];
            rec.src_b_reg   = instr[A_TYPE_LSB + 1];
            rec.src_c_reg   = instr[A_TYPE_LSB + 2];
            rec.dest_reg    = instr[A_TYPE_LSB + 3];
            rec.saturate    = ~instr[A_NOSAT_BIT];
            rec.instr_shift = SHIFT_WIDTH'(instr[A_PMS_LSB +: PMS_WIDTH]);
        end
    end

endmodule

// File: rtl/instr_decode_pipe.sv
// Handshaked block instruction decoder: output register plus one-entry skid,
// with RAW hazard distance built only when INSTR_DEC_HAZARD_EN is defined.
//
// slot state | meaning
// SLOT_EMPTY | slot holds no record
// SLOT_FULL  | slot holds a record awaiting transfer
module instr_decode_pipe
    import instr_dec_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int OP_WIDTH       = 5,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int RES_ADDR_WIDTH = 8,
    parameter int PMS_WIDTH      = 4,
    parameter int SHIFT_WIDTH    = 5,
    parameter int HAZARD_DEPTH   = 4,
    parameter int INSTR_WIDTH    = OP_WIDTH + 4*REG_ADDR_WIDTH + 5 + PMS_WIDTH
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [INSTR_WIDTH-1:0]           in_instr,
    input  logic                             in_block_start,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [OP_WIDTH-1:0]              operation,
    output logic [REG_ADDR_WIDTH-1:0]        src_a,
    output logic [REG_ADDR_WIDTH-1:0]        src_b,
    output logic [REG_ADDR_WIDTH-1:0]        src_c,
    output logic [REG_ADDR_WIDTH-1:0]        dest,
    output logic                             src_a_reg,
    output logic                             src_b_reg,
    output logic                             src_c_reg,
    output logic                             dest_reg,
    output logic                             saturate,
    output logic [SHIFT_WIDTH-1:0]           instr_shift,
    output logic [RES_ADDR_WIDTH-1:0]        res_addr,
    output logic                             format_b,
    output logic [$clog2(HAZARD_DEPTH+1)-1:0] hazard_dist
);

    localparam int HAZ_W = $clog2(HAZARD_DEPTH + 1);
    localparam int unused_data_width = DATA_WIDTH;

    slot_e      out_state, out_state_nxt, skid_state, skid_state_nxt;
    instr_rec_t dec, out_rec, out_rec_nxt, skid_rec, skid_rec_nxt;
    logic [HAZ_W-1:0] new_hz, out_hz, out_hz_nxt, skid_hz, skid_hz_nxt;
    logic in_ready_q, in_ready_nxt, accept, drain;

    instr_field_extract u_extract (
        .instr (in_instr),
        .rec   (dec)
    );

    assign accept = in_valid & in_ready_q;
    assign drain  = (out_state == SLOT_FULL) & out_ready;

`ifdef INSTR_DEC_HAZARD_EN
    logic [HAZARD_DEPTH-1:0]   hist_valid;
    logic [REG_ADDR_WIDTH-1:0] hist_dest [HAZARD_DEPTH];

    // Entry 0 is the most recent instruction; descending scan lets the nearest match win.
    always_comb begin
        new_hz = '0;
        if (!in_block_start) begin
            for (int i = HAZARD_DEPTH - 1; i >= 0; i--) begin
                if (hist_valid[i] &&
                    ((dec.src_a_reg && (dec.src_a == hist_dest[i])) ||
                     (dec.src_b_reg && (dec.src_b == hist_dest[i])) ||
                     (dec.src_c_reg && (dec.src_c == hist_dest[i]))))
                    new_hz = HAZ_W'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_valid <= '0;
            for (int i = 0; i < HAZARD_DEPTH; i++) hist_dest[i] <= '0;
        end else if (accept) begin
            for (int i = HAZARD_DEPTH - 1; i > 0; i--) begin
                hist_valid[i] <= in_block_start ? 1'b0 : hist_valid[i-1];
                hist_dest[i]  <= hist_dest[i-1];
            end
            hist_valid[0] <= (dec.fmt == FMT_A) && dec.dest_reg;
            hist_dest[0]  <= dec.dest;
        end
    end
`else
    logic unused_block_start;
    assign unused_block_start = in_block_start;
    assign new_hz = '0;
`endif

    always_comb begin
        out_state_nxt  = out_state;
        skid_state_nxt = skid_state;
        out_rec_nxt    = out_rec;
        out_hz_nxt     = out_hz;
        skid_rec_nxt   = skid_rec;
        skid_hz_nxt    = skid_hz;
        if (drain) begin
            if (skid_state == SLOT_FULL) begin
                out_rec_nxt    = skid_rec;
                out_hz_nxt     = skid_hz;
                skid_state_nxt = SLOT_EMPTY;
            end else if (accept) begin
                out_rec_nxt = dec;
                out_hz_nxt  = new_hz;
            end else begin
                out_state_nxt = SLOT_EMPTY;
            end
        end else if (accept) begin
            if (out_state == SLOT_FULL) begin
                skid_rec_nxt   = dec;
                skid_hz_nxt    = new_hz;
                skid_state_nxt = SLOT_FULL;
            end else begin
                out_rec_nxt   = dec;
                out_hz_nxt    = new_hz;
                out_state_nxt = SLOT_FULL;
            end
        end
        in_ready_nxt = (skid_state_nxt == SLOT_EMPTY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_state  <= SLOT_EMPTY;
            skid_state <= SLOT_EMPTY;
            out_rec    <= '0;
            out_hz     <= '0;
            skid_rec   <= '0;
            skid_hz    <= '0;
            in_ready_q <= 1'b0;
        end else begin
            out_state  <= out_state_nxt;
            skid_state <= skid_state_nxt;
            out_rec    <= out_rec_nxt;
            out_hz     <= out_hz_nxt;
            skid_rec   <= skid_rec_nxt;
            skid_hz    <= skid_hz_nxt;
            in_ready_q <= in_ready_nxt;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (out_state == SLOT_FULL);
    assign operation   = out_rec.operation;
    assign src_a       = out_rec.src_a;
    assign src_b       = out_rec.src_b;
    assign src_c       = out_rec.src_c;
    assign dest        = out_rec.dest;
    assign src_a_reg   = out_rec.src_a_reg;
    assign src_b_reg   = out_rec.src_b_reg;
    assign src_c_reg   = out_rec.src_c_reg;
    assign dest_reg    = out_rec.dest_reg;
    assign saturate    = out_rec.saturate;
    assign instr_shift = out_rec.instr_shift;
    assign res_addr    = out_rec.res_addr;
    assign format_b    = (out_rec.fmt == FMT_B);
    assign hazard_dist = out_hz;

endmodule

// File: tb/tb_instr_decode_pipe.sv
// Scoreboard bench for instr_decode_pipe; hazard expectations follow INSTR_DEC_HAZARD_EN.
module tb_instr_decode_pipe;
    import instr_dec_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_block_start = 1'b0;
    logic        out_ready = 1'b0;
    logic [29:0] in_instr = '0;
    logic        in_ready, out_valid;
    logic [4:0]  operation;
    logic [3:0]  src_a, src_b, src_c, dest;
    logic        src_a_reg, src_b_reg, src_c_reg, dest_reg, saturate, format_b;
    logic [4:0]  instr_shift;
    logic [7:0]  res_addr;
    logic [2:0]  hazard_dist;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    bit          rand_bp = 1'b0;
    logic [39:0] exp_q[$];
    logic [2:0]  hz_q[$];
    bit          hv[4];
    logic [3:0]  hd[4];

    instr_decode_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_block_start(in_block_start),
        .out_valid(out_valid), .out_ready(out_ready), .operation(operation),
        .src_a(src_a), .src_b(src_b), .src_c(src_c), .dest(dest),
        .src_a_reg(src_a_reg), .src_b_reg(src_b_reg), .src_c_reg(src_c_reg),
        .dest_reg(dest_reg), .saturate(saturate), .instr_shift(instr_shift),
        .res_addr(res_addr), .format_b(format_b), .hazard_dist(hazard_dist)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [39:0] pack_out();
        return {operation, src_a, src_b, src_c, dest, src_a_reg, src_b_reg, src_c_reg,
                dest_reg, saturate, instr_shift, res_addr, format_b};
    endfunction

    function automatic logic [2:0] model_hz(input logic [3:0] sa, input logic [3:0] sb,
                                            input logic [3:0] sc, input logic [3:0] ty,
                                            input logic blk);
        logic [2:0] h = '0;
`ifdef INSTR_DEC_HAZARD_EN
        if (!blk)
            for (int i = 0; i < 4; i++)
                if (h == 3'd0 && hv[i] &&
                    ((ty[0] && sa == hd[i]) || (ty[1] && sb == hd[i]) || (ty[2] && sc == hd[i])))
                    h = 3'(i + 1);
`endif
        return h;
    endfunction

    task automatic hist_push(input bit v, input logic [3:0] d, input bit blk);
        if (blk) for (int i = 0; i < 4; i++) hv[i] = 1'b0;
        for (int i = 3; i > 0; i--) begin
            hv[i] = hv[i-1];
            hd[i] = hd[i-1];
        end
        hv[0] = v;
        hd[0] = d;
    endtask

    task automatic hist_clear();
        for (int i = 0; i < 4; i++) begin
            hv[i] = 1'b0;
            hd[i] = '0;
        end
    endtask

    task automatic wait_accept();
        int k = 0;
        while (!in_ready && k < 60) begin
            @(negedge clk);
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
            k++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_block_start = 1'b0;
        check_eq("accept_timeout", 64'(k >= 60), 64'(0));
    endtask

    task automatic present(input logic [29:0] ins, input bit blk, input logic [39:0] e,
                           input logic [2:0] h);
        in_instr = ins;
        in_block_start = blk;
        in_valid = 1'b1;
        exp_q.push_back(e);
        hz_q.push_back(h);
    endtask

    task automatic send_a(input logic [4:0] op, input logic [3:0] sa, input logic [3:0] sb,
                          input logic [3:0] sc, input logic [3:0] d, input logic [3:0] ty,
                          input logic ns, input logic [3:0] pms, input bit blk, input bit hold);
        logic [2:0] h;
        h = model_hz(sa, sb, sc, ty, blk);
        hist_push(ty[3], d, blk);
        present({pms, ns, ty, d, sc, sb, sa, op}, blk,
                {op, sa, sb, sc, d, ty[0], ty[1], ty[2], ty[3], ~ns, {1'b0, pms}, 8'h00, 1'b0}, h);
        if (!hold) wait_accept();
    endtask

    task automatic send_b(input logic [4:0] op, input logic [3:0] sa, input logic [3:0] sb,
                          input logic [3:0] d, input logic [7:0] res, input bit blk, input bit hold);
        hist_push(1'b0, d, blk);
        present({5'b0, res, d, sb, sa, op}, blk,
                {op, sa, sb, 4'h0, d, 4'h0, 1'b0, 5'h0, res, 1'b1}, 3'd0);
        if (!hold) wait_accept();
    endtask

    task automatic wait_drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_eq("drain_all", 64'(exp_q.size()), 64'(0));
    endtask

    // Handshake at the next posedge is visible here; stalled outputs must match the head.
    always @(negedge clk) begin
        #2;
        if (!reset && out_valid && exp_q.size() != 0) begin
            if (out_ready) begin
                check_eq("out_record", 64'(pack_out()), 64'(exp_q.pop_front()));
                check_eq("hazard_dist", 64'(hazard_dist), 64'(hz_q.pop_front()));
            end else begin
                check_eq("stall_hold", 64'(pack_out()), 64'(exp_q[0]));
            end
        end else if (!reset && out_valid && out_ready) begin
            check_eq("unexpected_out", 64'(exp_q.size()), 64'(1));
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] a_ops[4];
        logic [4:0] b_ops[4];
        a_ops = '{OP_ADD, OP_SUB, OP_MUL, OP_MAC};
        b_ops = '{OP_DELAY, OP_SAVE, OP_LOAD, OP_MOV};
        hist_clear();

        repeat (3) @(negedge clk);
        check_eq("rst_in_ready", 64'(in_ready), 64'(0));
        check_eq("rst_out_valid", 64'(out_valid), 64'(0));
        check_eq("rst_outputs", 64'(pack_out()), 64'(0));
        check_eq("rst_hazard", 64'(hazard_dist), 64'(0));
        reset = 1'b0;
        @(negedge clk);
        check_eq("in_ready_after_rst", 64'(in_ready), 64'(1));
        out_ready = 1'b1;

        send_a(OP_ADD, 4'd1, 4'd2, 4'd3, 4'd4, 4'b1111, 1'b0, 4'd3, 1'b0, 1'b0);
        check_eq("fmt_a_latency", 64'(out_valid), 64'(1));
        send_b(OP_MOV, 4'd5, 4'd6, 4'd7, 8'hA5, 1'b0, 1'b0);
        check_eq("fmt_b_latency", 64'(out_valid), 64'(1));
        @(negedge clk);
        check_eq("idle_out_valid", 64'(out_valid), 64'(0));

        out_ready = 1'b0;
        send_a(OP_SUB, 4'd1, 4'd1, 4'd1, 4'd2, 4'b0000, 1'b1, 4'd7, 1'b0, 1'b0);
        send_a(OP_MUL, 4'd3, 4'd3, 4'd3, 4'd5, 4'b0101, 1'b0, 4'd15, 1'b0, 1'b0);
        check_eq("bp_in_ready_drop", 64'(in_ready), 64'(0));
        send_b(OP_LOAD, 4'd8, 4'd9, 4'd10, 8'h3C, 1'b0, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check_eq("bp_in_ready_hold", 64'(in_ready), 64'(0));
        end
        check_eq("bp_queue_depth", 64'(exp_q.size()), 64'(3));
        out_ready = 1'b1;
        wait_accept();
        wait_drain();

        send_a(OP_ADD, 4'd0, 4'd0, 4'd0, 4'd4, 4'b1000, 1'b0, 4'd0, 1'b1, 1'b0);
        send_a(OP_SUB, 4'd1, 4'd2, 4'd3, 4'd9, 4'b1111, 1'b0, 4'd0, 1'b0, 1'b0);
        send_a(OP_ADD, 4'd5, 4'd4, 4'd6, 4'd10, 4'b1010, 1'b0, 4'd0, 1'b0, 1'b0);
        send_a(OP_ADD, 4'd5, 4'd4, 4'd6, 4'd11, 4'b1000, 1'b0, 4'd0, 1'b0, 1'b0);
        send_a(OP_ADD, 4'd0, 4'd0, 4'd0, 4'd4, 4'b1000, 1'b0, 4'd0, 1'b0, 1'b0);
        send_a(OP_SUB, 4'd4, 4'd0, 4'd0, 4'd4, 4'b1001, 1'b0, 4'd0, 1'b1, 1'b0);
        send_a(OP_MUL, 4'd4, 4'd0, 4'd0, 4'd12, 4'b1001, 1'b0, 4'd0, 1'b0, 1'b0);
        wait_drain();

        rand_bp = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0)
                send_b(b_ops[$urandom_range(0, 3)], 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       8'($urandom_range(0, 255)), 1'($urandom_range(0, 7) == 0), 1'b0);
            else
                send_a(a_ops[$urandom_range(0, 3)], 4'($urandom_range(0, 3)),
                       4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                       4'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                       1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                       1'($urandom_range(0, 7) == 0), 1'b0);
        end
        rand_bp = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        out_ready = 1'b0;
        send_a(OP_MAC, 4'd7, 4'd7, 4'd7, 4'd7, 4'b1111, 1'b0, 4'd9, 1'b0, 1'b0);
        send_b(OP_SAVE, 4'd1, 4'd2, 4'd3, 8'hFF, 1'b0, 1'b0);
        check_eq("pre_rst_skid_full", 64'(in_ready), 64'(0));
        check_eq("pre_rst_out_valid", 64'(out_valid), 64'(1));
        reset = 1'b1;
        @(negedge clk);
        check_eq("midrst_out_valid", 64'(out_valid), 64'(0));
        check_eq("midrst_outputs", 64'(pack_out()), 64'(0));
        check_eq("midrst_hazard", 64'(hazard_dist), 64'(0));
        check_eq("midrst_in_ready", 64'(in_ready), 64'(0));
        exp_q.delete();
        hz_q.delete();
        hist_clear();
        reset = 1'b0;
        @(negedge clk);
        check_eq("in_ready_after_midrst", 64'(in_ready), 64'(1));
        check_eq("out_valid_after_midrst", 64'(out_valid), 64'(0));
        out_ready = 1'b1;
        send_a(OP_SUB, 4'd7, 4'd0, 4'd0, 4'd1, 4'b0001, 1'b0, 4'd2, 1'b0, 1'b0);
        wait_drain();
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
